car_sensor_fsm: RTL and testbench

- Parking-lot gate front end that turns two photo-sensor inputs into occupancy-counter commands.
- Sensor A is on the outside of the gate; sensor B is on the inside.
- The block synchronises and debounces the raw sensor pins, then tracks each car's passage with an FSM.
- It emits a one-cycle inc pulse for a completed entry and a one-cycle dec pulse for a completed exit. The lot occupancy counter consumes these pulses.

---
 rtl/car_sensor_fsm.sv | 151 +++++++++++++++
 tb/tb_car_sensor_fsm.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/car_sensor_fsm.sv
// Parking-gate front end: synchronises and debounces two photo sensors, then tracks car passages.
// Optional sticky error flag and internal error counter enabled by defining CAR_SENSOR_ERR_EN.
module car_sensor_fsm #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a_pin,
    input  logic b_pin,
    output logic inc,
    output logic dec,
    output logic busy,
    output logic err
);

    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, RESYNC} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] a_sync, b_sync;
    logic [1:0]             s, s_prev, f;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   changed;
    state_t                 state, nxt;
    logic                   inc_nxt, dec_nxt;

    assign s = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_pin};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_pin};
        end
    end

    // The edge on which s changes counts as the first stable cycle, so f
    // follows after DEBOUNCE_CYC consecutive edges observing the same pair.
    always_comb begin
        changed = (s != s_prev);
        cnt_nxt = changed ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_prev <= '0;
            f      <= '0;
            cnt    <= '0;
        end else begin
            s_prev <= s;
            if (s != f && cnt_nxt == CNT_LAST) begin
                f   <= s;
                cnt <= '0;
            end else if (changed || s == f) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_nxt;
            end
        end
    end

    always_comb begin
        nxt     = state;
        inc_nxt = 1'b0;
        dec_nxt = 1'b0;
        case (state)
            IDLE: case (f)
                2'b10:   nxt = EN1;
                2'b01:   nxt = EX1;
                2'b11:   nxt = RESYNC;
                default: nxt = IDLE;
            endcase
            EN1: case (f)
                2'b11:   nxt = EN2;
                2'b00:   nxt = IDLE;
                2'b01:   nxt = RESYNC;
                default: nxt = EN1;
            endcase
            EN2: case (f)
                2'b01:   nxt = EN3;
                2'b10:   nxt = EN1;
                2'b00:   nxt = RESYNC;
                default: nxt = EN2;
            endcase
            EN3: case (f)
                2'b00:   begin nxt = IDLE; inc_nxt = 1'b1; end
                2'b11:   nxt = EN2;
                2'b10:   nxt = RESYNC;
                default: nxt = EN3;
            endcase
            EX1: case (f)
                2'b11:   nxt = EX2;
                2'b00:   nxt = IDLE;
                2'b10:   nxt = RESYNC;
                default: nxt = EX1;
            endcase
            EX2: case (f)
                2'b10:   nxt = EX3;
                2'b01:   nxt = EX1;
                2'b00:   nxt = RESYNC;
                default: nxt = EX2;
            endcase
            EX3: case (f)
                2'b00:   begin nxt = IDLE; dec_nxt = 1'b1; end
                2'b11:   nxt = EX2;
                2'b01:   nxt = RESYNC;
                default: nxt = EX3;
            endcase
            RESYNC:  nxt = (f == 2'b00) ? IDLE : RESYNC;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            inc   <= 1'b0;
            dec   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= nxt;
            inc   <= inc_nxt;
            dec   <= dec_nxt;
            busy  <= (nxt != IDLE);
        end
    end

`ifdef CAR_SENSOR_ERR_EN
    logic [7:0] err_cnt;
    logic       enter_resync;

    assign enter_resync = (nxt == RESYNC) && (state != RESYNC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (enter_resync) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_car_sensor_fsm.sv
// Bench for car_sensor_fsm: directed gate scenarios plus random pin walks against a
// cycle-level model built from sample windows and a gate-position walk.
module tb_car_sensor_fsm;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic a_pin = 1'b0;
    logic b_pin = 1'b0;
    logic inc, dec, busy, err;

    int tests = 0;
    int fails = 0;

    car_sensor_fsm dut (
        .clk(clk), .reset_n(reset_n), .a_pin(a_pin), .b_pin(b_pin),
        .inc(inc), .dec(dec), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Model: pin samples per edge, debounced pair, and passage as (mode, position along gate).
    // mode 0 idle, 1 entering, 2 exiting, 3 waiting for clear beams.
    logic [1:0] hist[$];
    logic [1:0] f_m;
    int         mode, prog;
    logic       inc_m, dec_m, busy_m, err_m;
    int         inc_cnt, dec_cnt, busy_hi;

    function automatic int pos(input int m, input logic [1:0] p);
        if (p == 2'b00) return 0;
        if (p == 2'b11) return 2;
        if (m == 1) return (p == 2'b10) ? 1 : 3;
        return (p == 2'b01) ? 1 : 3;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC + DEB; i++) hist.push_back(2'b00);
        f_m = 2'b00; mode = 0; prog = 0;
        inc_m = 0; dec_m = 0; busy_m = 0; err_m = 0;
    endtask

    task automatic model_fsm();
        int prev_mode, j, d;
        prev_mode = mode;
        inc_m = 0; dec_m = 0;
        if (mode == 0) begin
            if (f_m == 2'b10)      begin mode = 1; prog = 1; end
            else if (f_m == 2'b01) begin mode = 2; prog = 1; end
            else if (f_m == 2'b11) mode = 3;
        end else if (mode == 3) begin
            if (f_m == 2'b00) mode = 0;
        end else begin
            j = pos(mode, f_m);
            d = (j - prog + 4) % 4;
            if (d == 2) mode = 3;
            else if (d != 0) begin
                if (j == 0) begin
                    if (prog == 3) begin
                        if (mode == 1) inc_m = 1; else dec_m = 1;
                    end
                    mode = 0;
                end else prog = j;
            end
        end
        busy_m = (mode != 0);
`ifdef CAR_SENSOR_ERR_EN
        if (mode == 3 && prev_mode != 3) err_m = 1;
`endif
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: update the model on the edge, compare on the following falling edge.
    task automatic tick();
        logic [1:0] pr;
        bit         stable;
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            pr = {a_pin, b_pin};
            model_fsm();
            hist.push_back(pr);
            void'(hist.pop_front());
            stable = 1;
            for (int i = 1; i < DEB; i++) if (hist[i] != hist[0]) stable = 0;
            if (stable && hist[0] != f_m) f_m = hist[0];
        end
        @(negedge clk);
        chk("inc", inc, inc_m);
        chk("dec", dec, dec_m);
        chk("busy", busy, busy_m);
        chk("err", err, err_m);
        inc_cnt += int'(inc);
        dec_cnt += int'(dec);
        busy_hi += int'(busy);
    endtask

    task automatic hold(input logic [1:0] p, input int n);
        {a_pin, b_pin} = p;
        repeat (n) tick();
    endtask

    task automatic clr();
        inc_cnt = 0; dec_cnt = 0; busy_hi = 0;
    endtask

    // Drive p and count ticks until sig rises (bounded); first tick is the sampling edge.
    task automatic lat(input logic [1:0] p, input int which, output int n);
        {a_pin, b_pin} = p;
        n = 0;
        do begin
            tick();
            n++;
        end while (((which == 0) ? busy : (which == 1) ? inc : dec) !== 1'b1 && n < 20);
    endtask

    initial begin
        int n;
        logic err_exp;
`ifdef CAR_SENSOR_ERR_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        clr();
        model_reset();

        // Reset with both beams blocked, then release: 11 lands the FSM in RESYNC.
        reset_n = 1'b0;
        hold(2'b11, 3);
        reset_n = 1'b1;
        lat(2'b11, 0, n);
        chk_int("reset_resync_latency", n, 7);
        hold(2'b00, 12);
        chk("reset_busy_cleared", busy, 1'b0);

        // Entry with latency check on the final 00.
        clr();
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
        lat(2'b00, 1, n);
        chk_int("entry_latency", n, 7);
        hold(2'b00, 10);
        chk_int("entry_inc_cnt", inc_cnt, 1);
        chk_int("entry_dec_cnt", dec_cnt, 0);

        // Exit.
        clr();
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 14);
        chk_int("exit_dec_cnt", dec_cnt, 1);
        chk_int("exit_inc_cnt", inc_cnt, 0);

        // Reversals.
        clr();
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 12);
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 12);
        chk_int("reversal_pulses", inc_cnt + dec_cnt, 0);
        chk("reversal_busy", busy, 1'b0);

        // Glitches: 3 cycles filtered, 4 cycles accepted.
        clr();
        hold(2'b10, 3); hold(2'b00, 15);
        chk_int("glitch3_busy", busy_hi, 0);
        clr();
        hold(2'b10, 4); hold(2'b00, 15);
        chk_int("glitch4_busy", int'(busy_hi > 0), 1);

        // Illegal jump then a good entry.
        clr();
        hold(2'b11, 10); hold(2'b00, 12);
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 14);
        chk_int("illegal_then_entry_inc", inc_cnt, 1);
        chk("illegal_err", err, err_exp);

        // Reset asserted while in EN2 abandons the passage.
        clr();
        hold(2'b10, 10); hold(2'b11, 10);
        reset_n = 1'b0;
        hold(2'b11, 2);
        chk("midreset_err_clear", err, 1'b0);
        reset_n = 1'b1;
        hold(2'b01, 10); hold(2'b00, 14);
        chk_int("midreset_inc_cnt", inc_cnt, 0);

        // Random walk of pin pairs with random hold lengths.
        for (int k = 0; k < 300; k++)
            hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 12)));
        hold(2'b00, 15);
        chk("final_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
